// File: rtl/uram_event_buffer_ctrl.sv
// uram_event_buffer_ctrl
// Slot bookkeeping and URAM access scheduler for the event buffers shared by
// the trigger-side writer, the event readout state machine and the firmware
// update path. Slots are handed out in ring order to the writer and the reader.
// Firmware loading is granted only once every stored event has drained and the
// readout machine has had DRAIN_CE phase ticks to settle back to header-idle.
//
// Ports
//   clk_i, rst_i       system clock, asynchronous active-high reset
//   clk_ce_i           readout phase enable (shared with the readout machine)
//   wr_done_i          writer finished filling slot wr_buffer_o (1-cycle pulse)
//   wr_buffer_o        slot the writer fills next
//   wr_full_o          writer must not start a new event
//   rd_buffer_o        slot being / to be read out
//   data_available_o   to readout machine data_available_i
//   complete_i         readout machine finished a slot (1-cycle pulse)
//   occupancy_o        number of full slots, 0..2^NBUF_BITS
//   fw_req_i           level request for firmware loading
//   fw_loading_o       firmware path owns the URAM
//   err_o              sticky: [0] write while full, [1] completion while empty
//   err_clr_i          clears err_o (a same-cycle error event wins)
module uram_event_buffer_ctrl #(
    parameter int NBUF_BITS = 2,
    parameter int DRAIN_CE  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clk_ce_i,
    input  logic                 wr_done_i,
    output logic [NBUF_BITS-1:0] wr_buffer_o,
    output logic                 wr_full_o,
    output logic [NBUF_BITS-1:0] rd_buffer_o,
    output logic                 data_available_o,
    input  logic                 complete_i,
    output logic [NBUF_BITS:0]   occupancy_o,
    input  logic                 fw_req_i,
    output logic                 fw_loading_o,
    output logic [1:0]           err_o,
    input  logic                 err_clr_i
);

    localparam logic [NBUF_BITS:0] OCC_MAX = {1'b1, {NBUF_BITS{1'b0}}};
    localparam int CNT_W = (DRAIN_CE > 1) ? $clog2(DRAIN_CE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CE - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_FW_GRANT = 2'd2,
        ST_FW_EXIT  = 2'd3
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_drain_cnt;
    logic [NBUF_BITS-1:0] r_wr_ptr;
    logic [NBUF_BITS-1:0] r_rd_ptr;
    logic [NBUF_BITS:0]   r_occ;
    logic [1:0]           r_err;
    logic                 r_wr_full;
    logic                 r_data_av;
    logic                 r_fw_loading;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [NBUF_BITS:0]   w_occ_nxt;
    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic                 w_wr_err;
    logic                 w_rd_err;

    // Both acceptances are judged on the pre-cycle occupancy, so a completion
    // arriving together with a write at full does not make that write legal.
    assign w_wr_ok  = wr_done_i  && (r_occ != OCC_MAX);
    assign w_rd_ok  = complete_i && (r_occ != '0);
    assign w_wr_err = wr_done_i  && (r_occ == OCC_MAX);
    assign w_rd_err = complete_i && (r_occ == '0);

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_occ_nxt = r_occ + 1'b1;
            2'b01:   w_occ_nxt = r_occ - 1'b1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_drain_cnt;
        case (r_state)
            ST_RUN: begin
                if (fw_req_i) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!fw_req_i) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else if (r_occ != '0) begin
                    // Settling time only counts once the ring is empty.
                    w_cnt_nxt = '0;
                end else if (clk_ce_i) begin
                    if (r_drain_cnt == CNT_LAST) begin
                        w_state_nxt = ST_FW_GRANT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_drain_cnt + 1'b1;
                    end
                end
            end
            ST_FW_GRANT: begin
                if (!fw_req_i) w_state_nxt = ST_FW_EXIT;
            end
            ST_FW_EXIT: begin
                // One phase tick lets the readout machine return to header-idle.
                if (clk_ce_i) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the
    // pointer/occupancy update of the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_RUN;
            r_drain_cnt  <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
            r_err        <= 2'b00;
            r_wr_full    <= 1'b0;
            r_data_av    <= 1'b0;
            r_fw_loading <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_drain_cnt  <= w_cnt_nxt;
            r_occ        <= w_occ_nxt;
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_err        <= (err_clr_i ? 2'b00 : r_err) | {w_rd_err, w_wr_err};
            r_wr_full    <= (w_occ_nxt == OCC_MAX) || (w_state_nxt != ST_RUN);
            r_data_av    <= (w_occ_nxt != '0) &&
                            ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN));
            r_fw_loading <= (w_state_nxt == ST_FW_GRANT);
        end
    end

    assign wr_buffer_o      = r_wr_ptr;
    assign rd_buffer_o      = r_rd_ptr;
    assign occupancy_o      = r_occ;
    assign err_o            = r_err;
    assign wr_full_o        = r_wr_full;
    assign data_available_o = r_data_av;
    assign fw_loading_o     = r_fw_loading;

endmodule

// File: tb/tb_uram_event_buffer_ctrl.sv
// Testbench for uram_event_buffer_ctrl: directed scenarios plus a randomized
// run, all compared against a slot-counting reference model.
module tb_uram_event_buffer_ctrl;

    localparam int NB   = 2;
    localparam int DCE  = 2;
    localparam int MAXO = 1 << NB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce  = 1'b0;
    logic          wr  = 1'b0;
    logic          cmp = 1'b0;
    logic          fw  = 1'b0;
    logic          clr = 1'b0;
    logic [NB-1:0] wr_buffer;
    logic [NB-1:0] rd_buffer;
    logic [NB:0]   occupancy;
    logic          wr_full;
    logic          data_av;
    logic          fw_loading;
    logic [1:0]    err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: total accepted writes/completions, a firmware phase
    // (0 normal, 1 draining, 2 granted, 3 exiting) and ticks seen while empty.
    int         m_wr, m_rd, m_phase, m_ticks;
    logic [1:0] m_err;

    uram_event_buffer_ctrl #(.NBUF_BITS(NB), .DRAIN_CE(DCE)) dut (
        .clk_i(clk), .rst_i(rst), .clk_ce_i(ce), .wr_done_i(wr),
        .wr_buffer_o(wr_buffer), .wr_full_o(wr_full), .rd_buffer_o(rd_buffer),
        .data_available_o(data_av), .complete_i(cmp), .occupancy_o(occupancy),
        .fw_req_i(fw), .fw_loading_o(fw_loading), .err_o(err), .err_clr_i(clr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_phase = 0; m_ticks = 0; m_err = 2'b00;
    endtask

    task automatic model_step(input logic w, input logic c, input logic f,
                              input logic e, input logic cl);
        int         occ;
        logic [1:0] ev;
        occ = m_wr - m_rd;
        ev  = {c && occ == 0, w && occ == MAXO};
        case (m_phase)
            0: if (f) m_phase = 1;
            1: begin
                if (!f) begin m_phase = 0; m_ticks = 0; end
                else if (occ != 0) m_ticks = 0;
                else if (e) begin
                    m_ticks++;
                    if (m_ticks == DCE) begin m_phase = 2; m_ticks = 0; end
                end
            end
            2: if (!f) m_phase = 3;
            default: if (e) m_phase = 0;
        endcase
        if (w && occ < MAXO) m_wr++;
        if (c && occ > 0) m_rd++;
        m_err = (cl ? 2'b00 : m_err) | ev;
    endtask

    // Drive one clock of stimulus; pulses drop after the edge, fw_req holds.
    task automatic tick(input logic w, input logic c, input logic f,
                        input logic e, input logic cl);
        wr = w; cmp = c; fw = f; ce = e; clr = cl;
        model_step(w, c, f, e, cl);
        @(posedge clk); #1;
        wr = 1'b0; cmp = 1'b0; ce = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if ({wr_buffer, rd_buffer, occupancy} !== '0) begin n_errors++; $display("FAIL reset_counts: got wr=%0d rd=%0d occ=%0d want 0 0 0", wr_buffer, rd_buffer, occupancy); end
        n_checks++; if ({wr_full, data_av, fw_loading, err} !== 5'b0) begin n_errors++; $display("FAIL reset_flags: got full=%b dav=%b fwl=%b err=%b want all 0", wr_full, data_av, fw_loading, err); end
        rst = 1'b0;
        model_reset();
        tick(0, 0, 0, 0, 0);
        n_checks++; if ({occupancy, wr_full, data_av} !== 5'b0) begin n_errors++; $display("FAIL reset_release: got occ=%0d full=%b dav=%b want 0 0 0", occupancy, wr_full, data_av); end
    endtask

    task automatic test_basic();
        tick(1, 0, 0, 0, 0);
        n_checks++; if ({occupancy, data_av, wr_buffer} !== {3'd1, 1'b1, 2'd1}) begin n_errors++; $display("FAIL basic_first_write: got occ=%0d dav=%b wr=%0d want 1 1 1", occupancy, data_av, wr_buffer); end
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        n_checks++; if (wr_buffer !== 2'd3) begin n_errors++; $display("FAIL basic_wr_buffer: got %0d want 3", wr_buffer); end
        n_checks++; if (occupancy !== 3'd3) begin n_errors++; $display("FAIL basic_occ3: got %0d want 3", occupancy); end
        n_checks++; if ({data_av, rd_buffer, wr_full} !== {1'b1, 2'd0, 1'b0}) begin n_errors++; $display("FAIL basic_dav_rd: got dav=%b rd=%0d full=%b want 1 0 0", data_av, rd_buffer, wr_full); end
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0);
        n_checks++; if ({occupancy, rd_buffer, data_av} !== {3'd0, 2'd3, 1'b0}) begin n_errors++; $display("FAIL basic_drain: got occ=%0d rd=%0d dav=%b want 0 3 0", occupancy, rd_buffer, data_av); end
    endtask

    task automatic test_full_err();
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 0);
        n_checks++; if ({wr_full, occupancy, wr_buffer} !== {1'b1, 3'd4, 2'd3}) begin n_errors++; $display("FAIL full_flag: got full=%b occ=%0d wr=%0d want 1 4 3", wr_full, occupancy, wr_buffer); end
        tick(1, 0, 0, 0, 0);
        n_checks++; if ({occupancy, err, wr_buffer} !== {3'd4, 2'b01, 2'd3}) begin n_errors++; $display("FAIL full_overwrite: got occ=%0d err=%b wr=%0d want 4 01 3", occupancy, err, wr_buffer); end
        tick(0, 0, 0, 0, 1);
        n_checks++; if (err !== 2'b00) begin n_errors++; $display("FAIL err_clear: got %b want 00", err); end
        tick(1, 0, 0, 0, 1);
        n_checks++; if (err !== 2'b01) begin n_errors++; $display("FAIL err_clear_vs_event: got %b want 01", err); end
        tick(0, 0, 0, 0, 1);
    endtask

    task automatic test_simultaneous();
        tick(1, 1, 0, 0, 0);
        n_checks++; if ({occupancy, rd_buffer, wr_buffer} !== {3'd3, 2'd0, 2'd3}) begin n_errors++; $display("FAIL simul_at_full: got occ=%0d rd=%0d wr=%0d want 3 0 3", occupancy, rd_buffer, wr_buffer); end
        n_checks++; if ({err, wr_full} !== {2'b01, 1'b0}) begin n_errors++; $display("FAIL simul_err: got err=%b full=%b want 01 0", err, wr_full); end
        tick(1, 1, 0, 0, 1);
        n_checks++; if ({occupancy, rd_buffer, wr_buffer, err} !== {3'd3, 2'd1, 2'd0, 2'b00}) begin n_errors++; $display("FAIL simul_both_ok: got occ=%0d rd=%0d wr=%0d err=%b want 3 1 0 00", occupancy, rd_buffer, wr_buffer, err); end
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        n_checks++; if ({occupancy, rd_buffer, err, data_av} !== {3'd0, 2'd0, 2'b10, 1'b0}) begin n_errors++; $display("FAIL empty_complete: got occ=%0d rd=%0d err=%b dav=%b want 0 0 10 0", occupancy, rd_buffer, err, data_av); end
        tick(0, 0, 0, 0, 1);
    endtask

    task automatic test_fw_drain();
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        n_checks++; if ({wr_full, fw_loading, data_av, occupancy} !== {1'b1, 1'b0, 1'b1, 3'd2}) begin n_errors++; $display("FAIL drain_entry: got full=%b fwl=%b dav=%b occ=%0d want 1 0 1 2", wr_full, fw_loading, data_av, occupancy); end
        tick(0, 1, 1, 0, 0);
        tick(0, 1, 1, 1, 0);
        n_checks++; if ({fw_loading, data_av, occupancy} !== {1'b0, 1'b0, 3'd0}) begin n_errors++; $display("FAIL drain_empty: got fwl=%b dav=%b occ=%0d want 0 0 0", fw_loading, data_av, occupancy); end
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 1, 0, 0);
        n_checks++; if (fw_loading !== 1'b0) begin n_errors++; $display("FAIL drain_one_tick: got fwl=%b want 0", fw_loading); end
        tick(0, 0, 1, 1, 0);
        n_checks++; if ({fw_loading, data_av, wr_full} !== 3'b101) begin n_errors++; $display("FAIL fw_grant: got fwl=%b dav=%b full=%b want 1 0 1", fw_loading, data_av, wr_full); end
    endtask

    task automatic test_fw_exit();
        tick(0, 0, 0, 0, 0);
        n_checks++; if ({fw_loading, wr_full} !== 2'b01) begin n_errors++; $display("FAIL exit_release: got fwl=%b full=%b want 0 1", fw_loading, wr_full); end
        tick(0, 0, 0, 0, 0);
        n_checks++; if (wr_full !== 1'b1) begin n_errors++; $display("FAIL exit_wait_ce: got full=%b want 1", wr_full); end
        tick(0, 0, 0, 1, 0);
        n_checks++; if ({wr_full, fw_loading} !== 2'b00) begin n_errors++; $display("FAIL exit_to_run: got full=%b fwl=%b want 0 0", wr_full, fw_loading); end
    endtask

    task automatic test_fw_abort();
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        n_checks++; if ({wr_full, data_av} !== 2'b11) begin n_errors++; $display("FAIL abort_drain: got full=%b dav=%b want 1 1", wr_full, data_av); end
        tick(0, 1, 1, 0, 0);
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 0);
        n_checks++; if ({wr_full, fw_loading, occupancy} !== {1'b0, 1'b0, 3'd0}) begin n_errors++; $display("FAIL abort_to_run: got full=%b fwl=%b occ=%0d want 0 0 0", wr_full, fw_loading, occupancy); end
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0);
        n_checks++; if ({fw_loading, wr_full} !== 2'b00) begin n_errors++; $display("FAIL abort_no_grant: got fwl=%b full=%b want 0 0", fw_loading, wr_full); end
    endtask

    task automatic test_async_reset();
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 1, 1, 0);
        n_checks++; if (fw_loading !== 1'b1) begin n_errors++; $display("FAIL arst_setup_grant: got fwl=%b want 1", fw_loading); end
        #2; rst = 1'b1; fw = 1'b0; #1;
        n_checks++; if ({fw_loading, wr_full, data_av, occupancy, wr_buffer, rd_buffer, err} !== '0) begin n_errors++; $display("FAIL arst_in_grant: got fwl=%b full=%b dav=%b occ=%0d wr=%0d rd=%0d err=%b want all 0", fw_loading, wr_full, data_av, occupancy, wr_buffer, rd_buffer, err); end
        @(posedge clk); #1; rst = 1'b0; model_reset();
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0);
        n_checks++; if ({occupancy, data_av} !== {3'd3, 1'b1}) begin n_errors++; $display("FAIL arst_setup_run: got occ=%0d dav=%b want 3 1", occupancy, data_av); end
        #2; rst = 1'b1; #1;
        n_checks++; if ({fw_loading, wr_full, data_av, occupancy, wr_buffer, rd_buffer, err} !== '0) begin n_errors++; $display("FAIL arst_in_run: got fwl=%b full=%b dav=%b occ=%0d wr=%0d rd=%0d err=%b want all 0", fw_loading, wr_full, data_av, occupancy, wr_buffer, rd_buffer, err); end
        @(posedge clk); #1; rst = 1'b0; model_reset();
    endtask

    task automatic test_random();
        logic       f;
        logic [NB:0] e_occ;
        logic        e_full, e_dav, e_fwl;
        f = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) f = ~f;
            tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), f,
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0));
            e_occ  = (NB+1)'(m_wr - m_rd);
            e_full = (m_wr - m_rd == MAXO) || (m_phase != 0);
            e_dav  = (m_wr != m_rd) && (m_phase < 2);
            e_fwl  = (m_phase == 2);
            n_checks++;
            if ({wr_buffer, rd_buffer, occupancy, wr_full, data_av, fw_loading, err} !==
                {NB'(m_wr % MAXO), NB'(m_rd % MAXO), e_occ, e_full, e_dav, e_fwl, m_err}) begin
                n_errors++;
                $display("FAIL random_cycle%0d: got wr=%0d rd=%0d occ=%0d full=%b dav=%b fwl=%b err=%b want wr=%0d rd=%0d occ=%0d full=%b dav=%b fwl=%b err=%b",
                         i, wr_buffer, rd_buffer, occupancy, wr_full, data_av, fw_loading, err,
                         m_wr % MAXO, m_rd % MAXO, e_occ, e_full, e_dav, e_fwl, m_err);
            end
        end
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_full_err();
        test_simultaneous();
        test_fw_drain();
        test_fw_exit();
        test_fw_abort();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
